// File: rtl/interp_pkg.sv
// Shared types and helpers for the lin_interp_up linear-interpolating upsampler.
package interp_pkg;

  localparam int BIT_WIDTH_DEF = 24;
  localparam int BEAT_W        = 5;   // holds beat index 1..16
  localparam int SHIFT_W       = 3;   // holds shift 0..4

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Factor select: 0..3 map straight through, 4..7 all saturate at x16.
  function automatic logic [SHIFT_W-1:0] sel_to_shift(input logic [2:0] interp_sel);
    return interp_sel[2] ? 3'd4 : interp_sel;
  endfunction

endpackage

// File: rtl/interp_step_calc.sv
// Combinational step: out = P + ((k * (C - P) [+ bias]) >>> s_l).
// Round-half-up bias is compiled in when LIN_INTERP_ROUND_EN is defined; otherwise floor.
module interp_step_calc
  import interp_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
  input  logic signed [BIT_WIDTH-1:0] prev,
  input  logic signed [BIT_WIDTH-1:0] cur,
  input  logic [BEAT_W-1:0]           beat,
  input  logic [SHIFT_W-1:0]          shift,
  output logic signed [BIT_WIDTH-1:0] out_data
);

  localparam int DIFF_W = BIT_WIDTH + 1;
  localparam int PROD_W = BIT_WIDTH + 6;

`ifdef LIN_INTERP_ROUND_EN
  localparam logic RND_EN = 1'b1;
`else
  localparam logic RND_EN = 1'b0;
`endif

  // Half an LSB of the shifted result; zero when not shifting so bypass stays exact.
  function automatic logic signed [PROD_W-1:0] round_bias(input logic [SHIFT_W-1:0] sh);
    logic signed [PROD_W-1:0] b;
    b = '0;
    if (RND_EN && (sh != '0)) b[sh - 3'd1] = 1'b1;
    return b;
  endfunction

  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] diff_x;
  logic signed [PROD_W-1:0] beat_x;
  logic signed [PROD_W-1:0] prev_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;

  // The sum always lies between P and C, so truncating to BIT_WIDTH cannot wrap.
  always_comb begin
    diff     = {cur[BIT_WIDTH-1], cur} - {prev[BIT_WIDTH-1], prev};
    diff_x   = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
    beat_x   = {{(PROD_W-BEAT_W){1'b0}}, beat};
    prev_x   = {{(PROD_W-BIT_WIDTH){prev[BIT_WIDTH-1]}}, prev};
    prod     = diff_x * beat_x;
    shifted  = (prod + round_bias(shift)) >>> shift;
    out_data = BIT_WIDTH'(prev_x + shifted);
  end

endmodule

// File: rtl/lin_interp_up.sv
// Linear-interpolating upsampler: each accepted sample C, with previous sample P, yields N = 2^s beats
// from P toward C ending exactly on C. Build option: define LIN_INTERP_ROUND_EN for round-half-up.
module lin_interp_up
  import interp_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  interp_sel,
  input  logic signed [BIT_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [BIT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready
);

  state_e                      state_p0;
  logic signed [BIT_WIDTH-1:0] prev_p0;
  logic signed [BIT_WIDTH-1:0] cur_p0;
  logic [BEAT_W-1:0]           beat_p0;
  logic [SHIFT_W-1:0]          shift_p0;
  logic                        vld_p0;

  logic [BEAT_W-1:0] n_beats;
  logic              last_beat;
  logic              in_xfer;
  logic              out_xfer;

  assign n_beats   = BEAT_W'(1) << shift_p0;
  assign last_beat = (beat_p0 == n_beats);
  assign vld_p0    = (state_p0 == ST_RUN);
  assign out_valid = vld_p0;
  // Accepting on the last drained beat keeps output beats contiguous across pairs.
  assign in_ready  = !reset && ((state_p0 == ST_IDLE) || (last_beat && out_ready));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = vld_p0 && out_ready;

  // Stage p0: pair registers and beat counter; out_data is a pure function of these.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= ST_IDLE;
      prev_p0  <= '0;
      cur_p0   <= '0;
      beat_p0  <= BEAT_W'(1);
      shift_p0 <= '0;
    end else if (in_xfer) begin
      state_p0 <= ST_RUN;
      prev_p0  <= cur_p0;
      cur_p0   <= in_data;
      beat_p0  <= BEAT_W'(1);
      shift_p0 <= sel_to_shift(interp_sel);
    end else if (out_xfer) begin
      if (last_beat) state_p0 <= ST_IDLE;
      else           beat_p0  <= beat_p0 + BEAT_W'(1);
    end
  end

  interp_step_calc #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_step (
    .prev    (prev_p0),
    .cur     (cur_p0),
    .beat    (beat_p0),
    .shift   (shift_p0),
    .out_data(out_data)
  );

endmodule

// File: tb/tb_lin_interp_up.sv
// Self-checking bench for lin_interp_up: directed scenarios plus randomized traffic against a reference model.
module tb_lin_interp_up;

  localparam int BW = 24;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           interp_sel = 3'd0;
  logic signed [BW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [BW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  longint got[$];
  logic   rdy_q[$];
  int     out_cyc[$];
  int     acc_cyc[$];

  lin_interp_up #(.BIT_WIDTH(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .interp_sel(interp_sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got.push_back(longint'(out_data));
      rdy_q.push_back(in_ready);
      out_cyc.push_back(cyc);
    end
    if (!reset && in_valid && in_ready) acc_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int shift_of(input logic [2:0] sel);
    int v;
    v = int'(sel);
    return (v > 3) ? 4 : v;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Beat k of N between p and c, from the plain arithmetic definition.
  function automatic longint model_beat(input longint p, input longint c, input int s, input int k);
    longint n, num;
    n   = longint'(1) << s;
    num = longint'(k) * (c - p);
`ifdef LIN_INTERP_ROUND_EN
    num = num + n / 2;
`endif
    return p + floor_div(num, n);
  endfunction

  // ---------------- helpers ----------------
  task automatic clear_q();
    got.delete(); rdy_q.delete(); out_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_q();
  endtask

  task automatic send(input longint val);
    int i;
    in_data  = BW'(val);
    in_valid = 1'b1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    n_cmp++;
    if (i >= 200) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready never rose for value %0d", val);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 400 && got.size() < n; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (got.size() < n) begin
      n_fail++;
      $display("FAIL out_timeout: got %0d outputs, needed %0d", got.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %b expected 0", out_valid); end
    clear_q();
  endtask

  task automatic test_ramp();
    longint exp_v[8] = '{0, 0, 0, 0, 100, 200, 300, 400};
    logic   exp_r[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    interp_sel = 3'd2;
    send(0);
    send(400);
    wait_outs(8);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin n_fail++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", i, got[i], exp_v[i]); end
      n_cmp++;
      if (rdy_q[i] !== exp_r[i]) begin n_fail++; $display("FAIL ramp_ready[%0d]: got %b expected %b", i, rdy_q[i], exp_r[i]); end
    end
    n_cmp++;
    if (out_cyc[4] != out_cyc[3] + 1) begin n_fail++; $display("FAIL ramp_bubble: beat5 cycle %0d expected %0d", out_cyc[4], out_cyc[3] + 1); end
    n_cmp++;
    if (out_cyc[0] != acc_cyc[0] + 1) begin n_fail++; $display("FAIL ramp_latency: first out cycle %0d expected %0d", out_cyc[0], acc_cyc[0] + 1); end
  endtask

  task automatic test_bypass();
    longint exp_v[3] = '{5, -7, 9};
    do_reset();
    interp_sel = 3'd0;
    send(5);
    send(-7);
    send(9);
    wait_outs(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin n_fail++; $display("FAIL bypass_data[%0d]: got %0d expected %0d", i, got[i], exp_v[i]); end
      n_cmp++;
      if (out_cyc[i] != acc_cyc[i] + 1) begin n_fail++; $display("FAIL bypass_latency[%0d]: got cycle %0d expected %0d", i, out_cyc[i], acc_cyc[i] + 1); end
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (acc_cyc[i] != acc_cyc[i-1] + 1) begin n_fail++; $display("FAIL bypass_ready[%0d]: accept cycle %0d expected %0d", i, acc_cyc[i], acc_cyc[i-1] + 1); end
    end
  endtask

  task automatic test_rounding();
`ifdef LIN_INTERP_ROUND_EN
    longint exp_v[6] = '{2, 3, 2, 0, -1, -3};
`else
    longint exp_v[6] = '{1, 3, 1, 0, -2, -3};
`endif
    do_reset();
    interp_sel = 3'd1;
    send(3);
    send(0);
    send(-3);
    wait_outs(6);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin n_fail++; $display("FAIL round_data[%0d]: got %0d expected %0d", i, got[i], exp_v[i]); end
    end
  endtask

  task automatic test_extremes();
`ifdef LIN_INTERP_ROUND_EN
    longint exp_first = -7340032;
`else
    longint exp_first = -7340033;
`endif
    do_reset();
    interp_sel = 3'd4;
    send(-8388608);
    send(8388607);
    wait_outs(32);
    n_cmp++;
    if (got[16] !== exp_first) begin n_fail++; $display("FAIL ext_first: got %0d expected %0d", got[16], exp_first); end
    n_cmp++;
    if (got[31] !== 64'sd8388607) begin n_fail++; $display("FAIL ext_last: got %0d expected 8388607", got[31]); end
    for (int i = 17; i < 32; i++) begin
      n_cmp++;
      if (got[i] < got[i-1]) begin n_fail++; $display("FAIL ext_monotonic[%0d]: got %0d after %0d", i, got[i], got[i-1]); end
    end
  endtask

  task automatic test_backpressure_sel();
    longint exp_q[$];
    do_reset();
    interp_sel = 3'd2;
    send(100);
    interp_sel = 3'd4;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 24'sd50) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid %b data %0d expected 1 / 50", i, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(1700);
    wait_outs(20);
    for (int k = 1; k <= 4; k++) exp_q.push_back(model_beat(0, 100, 2, k));
    for (int k = 1; k <= 16; k++) exp_q.push_back(model_beat(100, 1700, 4, k));
    n_cmp++;
    if (got.size() != 20) begin n_fail++; $display("FAIL stall_count: got %0d beats expected 20", got.size()); end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    interp_sel = 3'd2;
    send(400);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_data !== 24'sd200) begin n_fail++; $display("FAIL midrst_pre: got %0d expected 200", out_data); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst_data: got %0d expected 0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    clear_q();
    interp_sel = 3'd1;
    send(800);
    wait_outs(2);
    n_cmp++; if (got[0] !== 64'sd400) begin n_fail++; $display("FAIL midrst_out0: got %0d expected 400", got[0]); end
    n_cmp++; if (got[1] !== 64'sd800) begin n_fail++; $display("FAIL midrst_out1: got %0d expected 800", got[1]); end
  endtask

  task automatic test_random();
    longint exp_q[$];
    longint m_prev, m_cur;
    logic   acc_last, exp_rdy;
    logic [31:0] r;
    int pend, s;
    do_reset();
    m_prev = 0; m_cur = 0; acc_last = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!in_valid || acc_last) begin
        r = $urandom;
        in_valid   = ($urandom_range(0, 2) != 0);
        in_data    = (r[1:0] == 2'b00) ? {{12{r[20]}}, r[20:9]} : r[31:8];
        interp_sel = 3'($urandom_range(0, 7));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      pend    = exp_q.size();
      exp_rdy = (pend == 0) || (pend == 1 && out_ready);
      n_cmp++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", c, in_ready, exp_rdy); end
      n_cmp++;
      if (out_valid !== (pend > 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", c, out_valid, pend > 0); end
      if (pend > 0) begin
        n_cmp++;
        if (longint'(out_data) !== exp_q[0]) begin n_fail++; $display("FAIL rand_data@%0d: got %0d expected %0d", c, out_data, exp_q[0]); end
        if (out_ready) void'(exp_q.pop_front());
      end
      acc_last = in_valid && in_ready;
      if (acc_last) begin
        m_prev = m_cur;
        m_cur  = longint'(in_data);
        s      = shift_of(interp_sel);
        for (int k = 1; k <= (1 << s); k++) exp_q.push_back(model_beat(m_prev, m_cur, s, k));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_bypass();
    test_rounding();
    test_extremes();
    test_backpressure_sel();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lin_interp_up.md
LIN_INTERP_UP -- requirements
Module: lin_interp_up

Interface
REQ-001 SHALL have parameter: BIT_WIDTH, 24, signed sample width.
REQ-002 SHALL have port: clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: interp_sel  input  3  interpolation factor select.
REQ-005 SHALL have port: in_data  input  BIT_WIDTH  signed low-rate sample.
REQ-006 SHALL have port: in_valid  input  1  in_data valid.
REQ-007 SHALL have port: in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port: out_data  output  BIT_WIDTH  signed interpolated sample.
REQ-009 SHALL have port: out_valid  output  1  out_data valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts out_data.

Function
REQ-011 SHALL map interp_sel to factor N = 2^s, with s = interp_sel for 0..3 and s = 4 for 4..7 (N = 1, 2, 4, 8, 16).
REQ-012 SHALL hold registers P (previous sample), C (current sample), k (beat index 1..N) and latched shift s_l.
REQ-013 SHALL transfer an input on in_valid && in_ready: P <= C, C <= in_data, k <= 1, s_l <= s(interp_sel).
REQ-014 SHALL use two states:
- IDLE: out_valid = 0, in_ready = 1.
- RUN: out_valid = 1.
REQ-015 SHALL transition IDLE -> RUN on input transfer.
REQ-016 SHALL transfer an output on out_valid && out_ready in RUN:
- k < N: k <= k+1.
- k == N: go to IDLE, unless an input transfers the same cycle, in which case stay in RUN with the new pair.
REQ-017 SHALL drive in_ready = (IDLE) || (RUN && k == N && out_ready), giving one output per cycle with no bubble between pairs.
REQ-018 SHALL compute out_data = P + ((k * (C - P)) >>> s_l), with C - P at BIT_WIDTH+1 bits, the product at BIT_WIDTH+6 bits and an arithmetic shift; the result SHALL be truncated to BIT_WIDTH without overflow, since it always lies between P and C.
REQ-019 SHALL produce a final beat (k == N) exactly equal to C.
REQ-020 SHALL derive out_data and out_valid from registers only, with no combinational path from in_data or in_valid.
REQ-021 SHALL give latency: first output valid in the cycle after input transfer.
REQ-022 SHALL hold out_data, out_valid and k stable while out_valid && !out_ready.
REQ-023 SHALL ignore interp_sel changes during RUN; they take effect at the next input transfer.
REQ-024 SHALL drop an input presented while in_ready = 0; the upstream must hold it, per handshake.

Reset
REQ-025 SHALL, on reset high at a clock edge, set state = IDLE, P = C = 0, k = 1, s_l = 0, out_valid = 0 and out_data = 0, from any state including mid-RUN, discarding the pending pair.
REQ-026 SHALL force in_ready = 0 while reset is asserted and 1 in the first cycle after deassertion.

Configuration
REQ-027 SHALL recognise macro LIN_INTERP_ROUND_EN:
- Defined: add 2^(s_l-1) to the product before the shift when s_l > 0 (round half up).
- Undefined: floor via plain arithmetic shift.
- REQ-019 holds in both builds.

Structure
REQ-028 SHALL place in package interp_pkg: BIT_WIDTH default, the state enum, and function sel_to_shift(interp_sel) returning s.
REQ-029 SHALL isolate the REQ-018/REQ-027 datapath in one combinational sub-module, interp_step_calc (inputs P, C, k, s_l; output out_data).

Verification
REQ-030 SHALL cover basic ramp: reset, sel=2, inputs 0 then 400, out_ready=1 -> outputs 0,0,0,0 then 100,200,300,400, with in_ready high on each 4th beat.
REQ-031 SHALL cover bypass: sel=0, inputs 5, -7, 9 back-to-back -> outputs 5, -7, 9 one cycle after each accept, and in_ready constantly 1.
REQ-032 SHALL cover rounding: sel=1, P=0, C=3 -> 1,3 (floor) or 2,3 (LIN_INTERP_ROUND_EN); C=-3 -> -2,-3 or -1,-3.
REQ-033 SHALL cover extremes: sel=4, P=-8388608, C=8388607 -> first output -7340033, last 8388607, no wrap.
REQ-034 SHALL cover backpressure and sel change: out_ready low 5 cycles mid-burst -> out_data/k frozen; sel changed 2->4 during RUN -> burst still 4 beats, next pair 16 beats.
REQ-035 SHALL cover reset mid-RUN at k=2 -> next cycle out_valid=0, out_data=0; a subsequent input 800 with sel=1 yields 400, 800.
